// File: rtl/mips32_mem_arbiter.sv
// Fixed-priority arbiter (DBG > DMEM > IMEM, with an IMEM starvation guard) that serialises
// single-port memory accesses through ISSUE/WAIT/DONE and returns read data to the owner.
module mips32_mem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    input  logic          dbg_req,
    input  logic          imem_req,
    input  logic          dmem_req,
    input  logic          dbg_we,
    input  logic          dmem_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [AW-1:0] dmem_addr,
    input  logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic [DW-1:0] dmem_wdata,
    output logic          dbg_done,
    output logic          dmem_done,
    output logic          imem_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_DBG, OWN_DMEM, OWN_IMEM} owner_t;

    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    state_t        state;
    owner_t        owner;
    logic [CW-1:0] wcnt;
    logic [SW-1:0] starve;

    logic          imem_elig;
    logic          gnt_dbg, gnt_dmem, gnt_imem;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign imem_elig = imem_req & ~halted;

    // Once IMEM has lost STARVE_LIMIT decisions in a row it outranks DMEM (never DBG).
    always_comb begin
        gnt_dbg  = dbg_req;
        gnt_dmem = 1'b0;
        gnt_imem = 1'b0;
        if (!dbg_req) begin
            if (starve == SLIM) begin
                if (imem_elig)     gnt_imem = 1'b1;
                else if (dmem_req) gnt_dmem = 1'b1;
            end else begin
                if (dmem_req)       gnt_dmem = 1'b1;
                else if (imem_elig) gnt_imem = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt_dbg) begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end else if (gnt_dmem) begin
            sel_we    = dmem_we;
            sel_addr  = dmem_addr;
            sel_wdata = dmem_wdata;
        end else if (gnt_imem) begin
            sel_addr  = imem_addr;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_DBG;
            wcnt      <= '0;
            starve    <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            dbg_done  <= 1'b0;
            dmem_done <= 1'b0;
            imem_done <= 1'b0;
        end else begin
            dbg_done  <= 1'b0;
            dmem_done <= 1'b0;
            imem_done <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (gnt_dbg || gnt_dmem || gnt_imem) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        owner     <= gnt_dbg ? OWN_DBG : (gnt_dmem ? OWN_DMEM : OWN_IMEM);
                        // The memory strobe register doubles as the latched payload.
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        if (gnt_imem)
                            starve <= '0;
                        else if (imem_elig && starve != SLIM)
                            starve <= starve + SW'(1);
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    wcnt  <= CW'(LATENCY - 1);
                end
                WAIT: begin
                    if (wcnt == '0) begin
                        state <= DONE;
                        rdata <= mem_rdata;
                        case (owner)
                            OWN_DBG:  dbg_done  <= 1'b1;
                            OWN_DMEM: dmem_done <= 1'b1;
                            default:  imem_done <= 1'b1;
                        endcase
                    end else begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: a one-cycle-latency memory model, per-cycle bus log,
// and one task per scenario checking timing, ordering and data against hand-derived values.
module tb_mips32_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        halted;
    logic        dbg_req, imem_req, dmem_req;
    logic        dbg_we, dmem_we;
    logic [9:0]  dbg_addr, dmem_addr, imem_addr;
    logic [31:0] dbg_wdata, dmem_wdata;
    logic        dbg_done, dmem_done, imem_done;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int cmp   = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] mem [1024];
    logic [31:0] prog [7];

    logic        log_en    [1024];
    logic        log_we    [1024];
    logic [9:0]  log_addr  [1024];
    logic [31:0] log_wdata [1024];
    logic [2:0]  log_done  [1024];
    logic        log_busy  [1024];
    logic [31:0] log_rdata [1024];

    // Per-port request lists: 0 = DBG, 1 = DMEM, 2 = IMEM.
    logic [9:0]  t_addr [3][16];
    logic        t_we   [3][16];
    logic [31:0] t_data [3][16];
    int          p_n    [3];
    int          p_i    [3];

    mips32_mem_arbiter #(.AW(10), .DW(32), .LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk1(clk1), .rst(rst), .halted(halted),
        .dbg_req(dbg_req), .imem_req(imem_req), .dmem_req(dmem_req),
        .dbg_we(dbg_we), .dmem_we(dmem_we),
        .dbg_addr(dbg_addr), .dmem_addr(dmem_addr), .imem_addr(imem_addr),
        .dbg_wdata(dbg_wdata), .dmem_wdata(dmem_wdata),
        .dbg_done(dbg_done), .dmem_done(dmem_done), .imem_done(imem_done),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    always @(posedge clk1) begin
        if (rst) mem[5] <= 32'h2801000a;
        else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk1) begin
        if (cyc < 1024) begin
            log_en[cyc]    <= mem_en;
            log_we[cyc]    <= mem_we;
            log_addr[cyc]  <= mem_addr;
            log_wdata[cyc] <= mem_wdata;
            log_done[cyc]  <= {imem_done, dmem_done, dbg_done};
            log_busy[cyc]  <= busy;
            log_rdata[cyc] <= rdata;
        end
    end

    task automatic drive(int p);
        case (p)
            0: begin
                dbg_req = 1'b1; dbg_we = t_we[0][p_i[0]];
                dbg_addr = t_addr[0][p_i[0]]; dbg_wdata = t_data[0][p_i[0]];
            end
            1: begin
                dmem_req = 1'b1; dmem_we = t_we[1][p_i[1]];
                dmem_addr = t_addr[1][p_i[1]]; dmem_wdata = t_data[1][p_i[1]];
            end
            default: begin
                imem_req = 1'b1; imem_addr = t_addr[2][p_i[2]];
            end
        endcase
    endtask

    task automatic start_port(int p, int n);
        p_n[p] = n;
        p_i[p] = 0;
        drive(p);
    endtask

    // Advance one cycle; a requester moves to its next item (or drops req) after its done.
    task automatic tick();
        logic [2:0] seen;
        @(negedge clk1);
        seen = {imem_done, dmem_done, dbg_done};
        @(posedge clk1);
        #1;
        for (int p = 0; p < 3; p++) begin
            if (seen[p]) begin
                p_i[p] = p_i[p] + 1;
                if (p_i[p] < p_n[p]) drive(p);
                else if (p == 0) dbg_req = 1'b0;
                else if (p == 1) dmem_req = 1'b0;
                else imem_req = 1'b0;
            end
        end
    endtask

    task automatic run_idle(int maxc, output bit ok);
        int n = 0;
        while ((dbg_req || dmem_req || imem_req || busy) && n < maxc) begin
            tick();
            n++;
        end
        ok = !(dbg_req || dmem_req || imem_req || busy);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        cmp++;
        if ({busy, mem_en, mem_we, dbg_done, dmem_done, imem_done} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, mem_en, mem_we, dbg_done, dmem_done, imem_done});
        end
        cmp++;
        if ({mem_addr, mem_wdata, rdata} !== 74'b0) begin
            fails++;
            $display("FAIL reset_data: got addr %h wdata %h rdata %h want 0", mem_addr, mem_wdata, rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int c0;
        bit ok;
        t_addr[1][0] = 10'd5; t_we[1][0] = 1'b0; t_data[1][0] = 32'h0;
        c0 = cyc;
        start_port(1, 1);
        run_idle(50, ok);
        cmp++;
        if (!ok) begin fails++; $display("FAIL single_timeout: got busy after 50 cycles want idle"); end
        for (int k = 0; k < 6; k++) begin
            cmp++;
            if (log_en[c0+k] !== (k == 1)) begin
                fails++; $display("FAIL single_en[%0d]: got %b want %b", k, log_en[c0+k], k == 1);
            end
            cmp++;
            if (log_busy[c0+k] !== (k >= 1 && k <= 3)) begin
                fails++; $display("FAIL single_busy[%0d]: got %b want %b", k, log_busy[c0+k], k >= 1 && k <= 3);
            end
            cmp++;
            if (log_done[c0+k] !== ((k == 3) ? 3'b010 : 3'b000)) begin
                fails++; $display("FAIL single_done[%0d]: got %b want %b", k, log_done[c0+k], (k == 3) ? 3'b010 : 3'b000);
            end
        end
        cmp++;
        if (log_addr[c0+1] !== 10'd5 || log_we[c0+1] !== 1'b0) begin
            fails++; $display("FAIL single_addr: got %h we %b want 005 we 0", log_addr[c0+1], log_we[c0+1]);
        end
        cmp++;
        if (log_rdata[c0+3] !== 32'h2801000a) begin
            fails++; $display("FAIL single_rdata: got %h want 2801000a", log_rdata[c0+3]);
        end
    endtask

    task automatic test_load_and_fetch();
        int c0, c1, nen, ndn;
        bit ok;
        for (int i = 0; i < 7; i++) begin
            t_addr[0][i] = 10'(i); t_we[0][i] = 1'b1; t_data[0][i] = prog[i];
            t_addr[2][i] = 10'(i); t_we[2][i] = 1'b0; t_data[2][i] = 32'h0;
        end
        c0 = cyc;
        start_port(0, 7);
        run_idle(100, ok);
        cmp++;
        if (!ok) begin fails++; $display("FAIL load_timeout: got busy after 100 cycles want idle"); end
        c1 = cyc;
        start_port(2, 7);
        run_idle(100, ok);
        cmp++;
        if (!ok) begin fails++; $display("FAIL fetch_timeout: got busy after 100 cycles want idle"); end
        for (int i = 0; i < 7; i++) begin
            cmp++;
            if (log_en[c0+1+4*i] !== 1'b1 || log_we[c0+1+4*i] !== 1'b1 ||
                log_addr[c0+1+4*i] !== 10'(i) || log_wdata[c0+1+4*i] !== prog[i]) begin
                fails++;
                $display("FAIL load_wr[%0d]: got en %b we %b addr %h data %h want 1 1 %h %h", i,
                         log_en[c0+1+4*i], log_we[c0+1+4*i], log_addr[c0+1+4*i], log_wdata[c0+1+4*i], 10'(i), prog[i]);
            end
            cmp++;
            if (log_done[c0+3+4*i] !== 3'b001) begin
                fails++; $display("FAIL load_done[%0d]: got %b want 001", i, log_done[c0+3+4*i]);
            end
            cmp++;
            if (log_en[c1+1+4*i] !== 1'b1 || log_we[c1+1+4*i] !== 1'b0 || log_addr[c1+1+4*i] !== 10'(i)) begin
                fails++;
                $display("FAIL fetch_rd[%0d]: got en %b we %b addr %h want 1 0 %h", i,
                         log_en[c1+1+4*i], log_we[c1+1+4*i], log_addr[c1+1+4*i], 10'(i));
            end
            cmp++;
            if (log_done[c1+3+4*i] !== 3'b100 || log_rdata[c1+3+4*i] !== prog[i]) begin
                fails++;
                $display("FAIL fetch_data[%0d]: got done %b rdata %h want 100 %h", i,
                         log_done[c1+3+4*i], log_rdata[c1+3+4*i], prog[i]);
            end
        end
        nen = 0;
        ndn = 0;
        for (int c = c0; c < cyc; c++) begin
            nen += int'(log_en[c]);
            ndn += int'(log_done[c] != 3'b000);
            cmp++;
            if (!$onehot0(log_done[c]) ||
                (!log_en[c] && (log_we[c] || log_addr[c] != '0 || log_wdata[c] != '0))) begin
                fails++;
                $display("FAIL bus_idle_or_done[%0d]: got en %b we %b addr %h data %h done %b want quiet bus, <=1 done",
                         c - c0, log_en[c], log_we[c], log_addr[c], log_wdata[c], log_done[c]);
            end
        end
        cmp++;
        if (nen != 14 || ndn != 14) begin
            fails++; $display("FAIL load_fetch_counts: got %0d strobes %0d dones want 14 14", nen, ndn);
        end
    endtask

    task automatic test_priority();
        int c0;
        bit ok;
        logic [9:0] exp_a [3];
        logic [2:0] exp_d [3];
        exp_a[0] = 10'd1;  exp_a[1] = 10'd2;  exp_a[2] = 10'd3;
        exp_d[0] = 3'b001; exp_d[1] = 3'b010; exp_d[2] = 3'b100;
        t_addr[0][0] = 10'd1; t_we[0][0] = 1'b1; t_data[0][0] = 32'h0000_0011;
        t_addr[1][0] = 10'd2; t_we[1][0] = 1'b0; t_data[1][0] = 32'h0;
        t_addr[2][0] = 10'd3;
        c0 = cyc;
        start_port(0, 1);
        start_port(1, 1);
        start_port(2, 1);
        run_idle(100, ok);
        cmp++;
        if (!ok) begin fails++; $display("FAIL prio_timeout: got busy after 100 cycles want idle"); end
        for (int j = 0; j < 3; j++) begin
            cmp++;
            if (log_en[c0+1+4*j] !== 1'b1 || log_addr[c0+1+4*j] !== exp_a[j]) begin
                fails++;
                $display("FAIL prio_grant[%0d]: got en %b addr %h want 1 %h", j, log_en[c0+1+4*j], log_addr[c0+1+4*j], exp_a[j]);
            end
            cmp++;
            if (log_done[c0+3+4*j] !== exp_d[j]) begin
                fails++; $display("FAIL prio_done[%0d]: got %b want %b", j, log_done[c0+3+4*j], exp_d[j]);
            end
        end
    endtask

    task automatic test_starvation();
        int c0;
        bit ok;
        logic [9:0] exp_a [11];
        logic [2:0] exp_d [11];
        for (int k = 0; k < 9; k++) begin
            t_addr[1][k] = 10'(16 + k); t_we[1][k] = 1'b0; t_data[1][k] = 32'h0;
        end
        t_addr[2][0] = 10'd40;
        t_addr[2][1] = 10'd41;
        exp_a[0] = 10'd16; exp_a[1] = 10'd17; exp_a[2] = 10'd18; exp_a[3]  = 10'd19;
        exp_a[4] = 10'd40; exp_a[5] = 10'd20; exp_a[6] = 10'd21; exp_a[7]  = 10'd22;
        exp_a[8] = 10'd23; exp_a[9] = 10'd41; exp_a[10] = 10'd24;
        for (int j = 0; j < 11; j++) exp_d[j] = (j == 4 || j == 9) ? 3'b100 : 3'b010;
        c0 = cyc;
        start_port(1, 9);
        start_port(2, 2);
        run_idle(200, ok);
        cmp++;
        if (!ok) begin fails++; $display("FAIL starve_timeout: got busy after 200 cycles want idle"); end
        for (int j = 0; j < 11; j++) begin
            cmp++;
            if (log_en[c0+1+4*j] !== 1'b1 || log_addr[c0+1+4*j] !== exp_a[j]) begin
                fails++;
                $display("FAIL starve_grant[%0d]: got en %b addr %h want 1 %h", j, log_en[c0+1+4*j], log_addr[c0+1+4*j], exp_a[j]);
            end
            cmp++;
            if (log_done[c0+3+4*j] !== exp_d[j]) begin
                fails++; $display("FAIL starve_done[%0d]: got %b want %b", j, log_done[c0+3+4*j], exp_d[j]);
            end
        end
    endtask

    task automatic test_halted();
        int c0, c1, nen;
        bit ok;
        t_addr[2][0] = 10'd6;
        halted = 1'b1;
        c0 = cyc;
        start_port(2, 1);
        repeat (20) tick();
        nen = 0;
        for (int c = c0; c < c0 + 20; c++) nen += int'(log_en[c] || log_busy[c]);
        cmp++;
        if (nen != 0) begin fails++; $display("FAIL halted_block: got %0d active cycles want 0", nen); end
        halted = 1'b0;
        c1 = cyc;
        run_idle(50, ok);
        cmp++;
        if (!ok) begin fails++; $display("FAIL halted_timeout: got busy after 50 cycles want idle"); end
        cmp++;
        if (log_en[c1+1] !== 1'b1 || log_addr[c1+1] !== 10'd6) begin
            fails++; $display("FAIL halted_resume_en: got en %b addr %h want 1 006", log_en[c1+1], log_addr[c1+1]);
        end
        cmp++;
        if (log_done[c1+3] !== 3'b100 || log_rdata[c1+3] !== prog[6]) begin
            fails++;
            $display("FAIL halted_resume_done: got done %b rdata %h want 100 %h", log_done[c1+3], log_rdata[c1+3], prog[6]);
        end
    endtask

    task automatic test_reset_mid();
        int c0, nd;
        bit ok;
        t_addr[1][0] = 10'd5; t_we[1][0] = 1'b0; t_data[1][0] = 32'h0;
        c0 = cyc;
        start_port(1, 1);
        tick();
        tick();
        cmp++;
        if (busy !== 1'b1 || mem_en !== 1'b0) begin
            fails++; $display("FAIL rstmid_in_wait: got busy %b en %b want 1 0", busy, mem_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp++;
        if ({busy, mem_en, mem_we, dbg_done, dmem_done, imem_done} !== 6'b0 ||
            {mem_addr, mem_wdata, rdata} !== 74'b0) begin
            fails++;
            $display("FAIL rstmid_outputs: got ctrl %b addr %h wdata %h rdata %h want all 0",
                     {busy, mem_en, mem_we, dbg_done, dmem_done, imem_done}, mem_addr, mem_wdata, rdata);
        end
        run_idle(50, ok);
        cmp++;
        if (!ok) begin fails++; $display("FAIL rstmid_timeout: got busy after 50 cycles want idle"); end
        nd = 0;
        for (int c = c0; c < c0 + 6; c++) nd += int'(log_done[c] != 3'b000);
        cmp++;
        if (nd != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", nd); end
        cmp++;
        if (log_en[c0+4] !== 1'b1 || log_addr[c0+4] !== 10'd5) begin
            fails++; $display("FAIL rstmid_reissue: got en %b addr %h want 1 005", log_en[c0+4], log_addr[c0+4]);
        end
        cmp++;
        if (log_done[c0+6] !== 3'b010 || log_rdata[c0+6] !== 32'h2801000a) begin
            fails++;
            $display("FAIL rstmid_done: got done %b rdata %h want 010 2801000a", log_done[c0+6], log_rdata[c0+6]);
        end
    endtask

    initial begin
        prog[0] = 32'h2001000a;
        prog[1] = 32'h20020014;
        prog[2] = 32'h00221820;
        prog[3] = 32'hac030010;
        prog[4] = 32'h8c040010;
        prog[5] = 32'h2801000a;
        prog[6] = 32'h08000000;
        for (int p = 0; p < 3; p++) begin
            p_n[p] = 0;
            p_i[p] = 0;
        end
        rst = 1'b1; halted = 1'b0;
        dbg_req = 1'b0; imem_req = 1'b0; dmem_req = 1'b0;
        dbg_we = 1'b0; dmem_we = 1'b0;
        dbg_addr = '0; dmem_addr = '0; imem_addr = '0;
        dbg_wdata = '0; dmem_wdata = '0;

        test_reset();
        test_single_read();
        test_load_and_fetch();
        test_priority();
        test_starvation();
        test_halted();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
